// File: rtl/sr_debug_pkg.sv
// Shared FSM state and frame constants for the debug register dump.
// Pure declarations: no logic, no latency, no flow control.
package sr_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_CAPTURE,
    ST_SEND,
    ST_NEXT
  } state_t;

  localparam logic [2:0] HEADER_TAG     = 3'b101;
  localparam int         BYTES_PER_REG  = 5;
  localparam int         BITS_PER_FRAME = 10;

  function automatic logic [7:0] header_byte(input logic [4:0] addr);
    return {HEADER_TAG, addr};
  endfunction

endpackage

// File: rtl/sr_uart_tx.sv
// UART 8N1 transmitter: byte accepted on valid&&ready, start bit on the next cycle.
// Ready drops while shifting and returns in the last stop-bit cycle so bytes can run back to back.
module sr_uart_tx
  import sr_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("sr_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  logic          r_active;
  logic [3:0]    r_bit_idx;
  logic [CW-1:0] r_clk_cnt;
  logic [8:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;
  logic          w_last;

  assign w_bit_end = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_last    = r_active && w_bit_end && (r_bit_idx == 4'(BITS_PER_FRAME - 1));
  assign ready     = !r_active || w_last;
  assign tx        = r_tx;

  // r_shift holds the bits still to go; its MSB of 1 becomes the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_bit_idx <= '0;
      r_clk_cnt <= '0;
      r_shift   <= '1;
      r_tx      <= 1'b1;
    end else if (valid && ready) begin
      r_active  <= 1'b1;
      r_bit_idx <= '0;
      r_clk_cnt <= '0;
      r_shift   <= {1'b1, data};
      r_tx      <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_clk_cnt <= '0;
        if (w_last) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_tx      <= r_shift[0];
          r_shift   <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sr_debug_reader.sv
// Sweeps regAddr over FIRST_REG..LAST_REG, captures each regData and sends it as a 5-byte UART frame.
// First start bit 3 cycles after start is sampled; start is ignored while busy (never queued).
module sr_debug_reader
  import sr_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIRST_REG    = 0,
  parameter int LAST_REG     = 31,
  parameter int IDLE_REG     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LP_FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LP_LAST  = 5'(LAST_REG);
  localparam logic [4:0] LP_IDLE  = 5'(IDLE_REG);

  if (LAST_REG < FIRST_REG) begin : g_bad_range
    $error("sr_debug_reader: LAST_REG must be >= FIRST_REG");
  end

  state_t      r_state;
  logic [4:0]  r_addr;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_shadow;
  logic [2:0]  r_byte_idx;
  logic        w_tx_vld;
  logic        w_tx_rdy;
  logic [7:0]  w_tx_dat;

  assign regAddr = r_addr;
  assign busy    = r_busy;
  assign done    = r_done;

  // The header goes out of CAPTURE directly so the first start bit follows without a gap.
  always_comb begin
    w_tx_vld = (r_state == ST_CAPTURE) || (r_state == ST_SEND);
    w_tx_dat = header_byte(r_addr);
    if (r_state == ST_SEND) begin
      case (r_byte_idx)
        3'd1:    w_tx_dat = r_shadow[31:24];
        3'd2:    w_tx_dat = r_shadow[23:16];
        3'd3:    w_tx_dat = r_shadow[15:8];
        3'd4:    w_tx_dat = r_shadow[7:0];
        default: w_tx_dat = header_byte(r_addr);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= LP_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shadow   <= '0;
      r_byte_idx <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SET;
            r_addr  <= LP_FIRST;
            r_busy  <= 1'b1;
          end
        end
        ST_SET: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          // The transmitter is always idle here, so the header is taken this cycle.
          r_shadow   <= regData;
          r_byte_idx <= 3'd1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_tx_rdy) begin
            r_byte_idx <= r_byte_idx + 3'd1;
            if (r_byte_idx == 3'(BYTES_PER_REG - 1)) r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (w_tx_rdy) begin
            if (r_addr == LP_LAST) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_addr  <= LP_IDLE;
            end else begin
              r_addr  <= r_addr + 5'd1;
              r_state <= ST_SET;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sr_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (w_tx_dat),
    .valid (w_tx_vld),
    .ready (w_tx_rdy),
    .tx    (tx)
  );

endmodule

// File: tb/tb_sr_debug_reader.sv
// Bench for sr_debug_reader: three instances (single register, full sweep, top-of-range restart)
// checked every cycle against a timeline model, plus literal byte/timing expectations.
module tb_sr_debug_reader;

  localparam int IDLE = 10;

  int p_c     [3] = '{4, 8, 4};
  int p_first [3] = '{10, 0, 30};
  int p_last  [3] = '{10, 31, 31};

  logic        clk     = 1'b0;
  logic [2:0]  rst_v   = 3'b111;
  logic [2:0]  start_v = 3'b000;
  logic [2:0]  tx_v, busy_v, done_v;
  logic [4:0]  addr_v [3];
  logic [31:0] rd_v   [3];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  bit act      [3] = '{1'b0, 1'b0, 1'b0};
  int n0       [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  bit zero_seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] base_word(input logic [4:0] a);
    return {27'b0, a} ^ 32'hA5A5A5A5;
  endfunction

  function automatic logic [31:0] noise(input int k);
    return (32'(k) * 32'h01030507) ^ 32'h5A5A0000;
  endfunction

  // Register-file contents per instance; instance 2 changes every cycle.
  function automatic logic [31:0] word_of(input int i, input logic [4:0] a, input int k);
    if (i == 0) return (a == 5'd10) ? 32'h00213D05 : 32'hFFFF0000;
    if (i == 1) return base_word(a);
    return base_word(a) ^ noise(k);
  endfunction

  // Line level m cycles after a register's SET began.
  function automatic logic exp_tx(input int c, input int m, input logic [4:0] a, input logic [31:0] w);
    int f, b, bi;
    logic [7:0] bv;
    if (m < 2) return 1'b1;
    f  = m - 2;
    b  = f / (10 * c);
    bi = (f % (10 * c)) / c;
    if (b == 0) bv = {3'b101, a};
    else        bv = w[8*(4-b) +: 8];
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return bv[bi-1];
  endfunction

  assign rd_v[0] = word_of(0, addr_v[0], 0);
  assign rd_v[1] = word_of(1, addr_v[1], 0);
  assign rd_v[2] = word_of(2, addr_v[2], cyc);

  sr_debug_reader #(.CLKS_PER_BIT(4), .FIRST_REG(10), .LAST_REG(10), .IDLE_REG(10)) u_dut_a (
    .clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .regAddr(addr_v[0]), .regData(rd_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  sr_debug_reader u_dut_b (
    .clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .regAddr(addr_v[1]), .regData(rd_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  sr_debug_reader #(.CLKS_PER_BIT(4), .FIRST_REG(30), .LAST_REG(31), .IDLE_REG(10)) u_dut_c (
    .clk(clk), .rst_n(rst_v[2]), .start(start_v[2]), .regAddr(addr_v[2]), .regData(rd_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // Per-cycle comparison against the dump timeline.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int         per, nreg, j, r;
      logic [4:0] ea;
      logic       eb, ed, et;
      bit         fin;
      per  = 2 + 50 * p_c[i];
      nreg = p_last[i] - p_first[i] + 1;
      ea = 5'(IDLE); eb = 1'b0; ed = 1'b0; et = 1'b1; fin = 1'b0;
      if (!rst_v[i]) begin
        act[i] = 1'b0;
      end else if (act[i]) begin
        j = cyc - n0[i];
        if (j < nreg * per) begin
          r  = j / per;
          ea = 5'(p_first[i] + r);
          eb = 1'b1;
          et = exp_tx(p_c[i], j % per, ea, word_of(i, ea, n0[i] + r * per + 1));
        end else begin
          ed  = 1'b1;
          fin = 1'b1;
        end
      end
      tests++;
      if (tx_v[i] !== et || busy_v[i] !== eb || done_v[i] !== ed || addr_v[i] !== ea) begin
        fails++;
        $display("FAIL cycle_check dut%0d cyc=%0d: got tx=%b busy=%b done=%b addr=%0d, want tx=%b busy=%b done=%b addr=%0d",
                 i, cyc, tx_v[i], busy_v[i], done_v[i], addr_v[i], et, eb, ed, ea);
      end
      if (done_v[i] === 1'b1) done_cnt[i]++;
      if (fin) act[i] = 1'b0;
      if (rst_v[i] && !act[i] && start_v[i]) begin
        act[i] = 1'b1;
        n0[i]  = cyc + 1;
      end
    end
    if (addr_v[2] === 5'd0) zero_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wait_done(input int i, input int limit, output int k);
    k = -1;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (done_v[i] === 1'b1) begin
        k = cyc;
        break;
      end
    end
    tests++;
    if (k < 0) begin
      fails++;
      $display("FAIL done_timeout dut%0d: no done within %0d cycles", i, limit);
    end
  endtask

  task automatic goto_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a_exp [5];
    logic [7:0] v;
    int ks, k0, kd, kd2, nb, low_cnt;
    a_exp = '{8'hAA, 8'h00, 8'h21, 8'h3D, 8'h05};

    #1 rst_v = 3'b000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_tx%0d", i),   {31'b0, tx_v[i]},   32'd1);
      check($sformatf("reset_busy%0d", i), {31'b0, busy_v[i]}, 32'd0);
      check($sformatf("reset_done%0d", i), {31'b0, done_v[i]}, 32'd0);
      check($sformatf("reset_addr%0d", i), {27'b0, addr_v[i]}, 32'd10);
    end
    @(posedge clk); #1 rst_v = 3'b111;
    repeat (2) @(posedge clk);

    // Single register, 4 clocks per bit: bytes AA 00 21 3D 05.
    #1 start_v[0] = 1'b1; ks = cyc;
    @(posedge clk); #1 start_v[0] = 1'b0;
    k0 = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (tx_v[0] === 1'b0) begin
        k0 = cyc;
        break;
      end
    end
    check("a_first_start_bit", 32'(k0 - ks), 32'd3);
    for (int b = 0; b < 5; b++) begin
      for (int bt = 0; bt < 8; bt++) begin
        while (cyc < k0 + b * 40 + (bt + 1) * 4 + 2) @(negedge clk);
        v[bt] = tx_v[0];
      end
      while (cyc < k0 + b * 40 + 9 * 4 + 2) @(negedge clk);
      check($sformatf("a_stop%0d", b), {31'b0, tx_v[0]}, 32'd1);
      check($sformatf("a_byte%0d", b), {24'b0, v}, {24'b0, a_exp[b]});
    end
    wait_done(0, 100, kd);
    check("a_done_after_start", 32'(kd - ks), 32'd203);
    check("a_done_after_first_bit", 32'(kd - k0), 32'd200);
    repeat (10) @(negedge clk);
    check("a_done_pulses", 32'(done_cnt[0]), 32'd1);

    // Full default sweep with an ignored start during the third frame.
    @(negedge clk);
    check("b_addr_before", {27'b0, addr_v[1]}, 32'd10);
    @(posedge clk); #1 start_v[1] = 1'b1; ks = cyc;
    @(posedge clk); #1 start_v[1] = 1'b0;
    goto_cycle(ks + 1 + 2 * 402 + 100);
    start_v[1] = 1'b1;
    @(posedge clk); #1 start_v[1] = 1'b0;
    wait_done(1, 13000, kd);
    check("b_total_cycles", 32'(kd - ks), 32'd12865);
    @(negedge clk);
    check("b_addr_after", {27'b0, addr_v[1]}, 32'd10);
    repeat (20) @(negedge clk);
    check("b_done_pulses", 32'(done_cnt[1]), 32'd1);

    // Reset in the middle of the start bit of byte 2, fifth frame.
    @(posedge clk); #1 start_v[1] = 1'b1; ks = cyc; nb = ks + 1;
    @(posedge clk); #1 start_v[1] = 1'b0;
    goto_cycle(nb + 4 * 402 + 2 + 20 * 8 + 4);
    check("b_pre_reset_tx_low", {31'b0, tx_v[1]}, 32'd0);
    check("b_pre_reset_addr", {27'b0, addr_v[1]}, 32'd4);
    #1 rst_v[1] = 1'b0;
    #1;
    check("b_async_tx", {31'b0, tx_v[1]}, 32'd1);
    check("b_async_busy", {31'b0, busy_v[1]}, 32'd0);
    check("b_async_addr", {27'b0, addr_v[1]}, 32'd10);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_v[1] = 1'b1;
    low_cnt = 0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (tx_v[1] !== 1'b1) low_cnt++;
    end
    check("b_quiet_after_reset", 32'(low_cnt), 32'd0);

    // Top of range with start held: two frames, done, immediate restart.
    @(posedge clk); #1 start_v[2] = 1'b1; ks = cyc;
    wait_done(2, 1000, kd);
    check("c_done_after_start", 32'(kd - ks), 32'd405);
    check("c_busy_low_at_done", {31'b0, busy_v[2]}, 32'd0);
    @(posedge clk); #1 start_v[2] = 1'b0;
    @(negedge clk);
    check("c_busy_restart", {31'b0, busy_v[2]}, 32'd1);
    check("c_addr_restart", {27'b0, addr_v[2]}, 32'd30);
    wait_done(2, 1000, kd2);
    check("c_restart_period", 32'(kd2 - kd), 32'd405);
    repeat (20) @(negedge clk);
    check("c_done_pulses", 32'(done_cnt[2]), 32'd2);
    check("c_addr_never_zero", {31'b0, zero_seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
